mlp_seq_classifier: RTL and testbench
=====================================

// Module: mlp_seq_classifier
// PURPOSE
//  Parametrised, time-multiplexed 2-layer binary-input MLP classifier (N_IN -> N_HID ReLU -> N_OUT argmax).
//  Weights live in a runtime-writable register file instead of constants.
//  Layer 1 computes one hidden neuron per cycle, layer 2 one class score per cycle, with a running argmax.
//  Sits between the pad inputs (feature bits) and the registered class output of the top-level wrapper.
// PARAMETERS
//  N_IN   8   number of binary input features
//  N_HID  4   number of hidden neurons
//  N_OUT  10  number of output classes (>=2)
//  W_W    10  signed width of every weight/bias word
//  HID_W  8   unsigned width of a hidden activation after ReLU+saturation
//  ACC_W  20  signed width of layer-2 score accumulator
//  localparams: DEPTH = N_HID*(N_IN+1) + N_OUT*(N_HID+1); B2 = N_HID*(N_IN+1);
//               AW = $clog2(DEPTH); CW = $clog2(N_OUT)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      request inference; accepted only when busy==0
//  x          in   N_IN   feature bits, sampled on start-accept edge
//  wr_en      in   1      weight write strobe
//  wr_addr    in   AW     weight word address
//  wr_data    in   W_W    signed weight/bias word
//  busy       out  1      inference in progress
//  done       out  1      one-cycle pulse: class_out valid/updated
//  class_out  out  CW     winning class index, held until next done
//  max_score  out  ACC_W  winning score (only with MLP_SCORE_OUT_EN)
// BEHAVIOUR
//  Reset (async): busy=0, done=0, class_out=0, max_score=0, FSM=IDLE, all weight words=0, hidden regs=0.
//  Weight map: L1 w[h][i] at h*(N_IN+1)+i, L1 bias[h] at h*(N_IN+1)+N_IN;
//   L2 w[o][j] at B2+o*(N_HID+1)+j, L2 bias[o] at B2+o*(N_HID+1)+N_HID.
//  Writes: take effect on the wr_en edge. Dropped if busy==1 or wr_addr>=DEPTH. No other side effect.
//  FSM IDLE -> L1 -> L2 -> IDLE.
//   IDLE: start=1 latches x, clears counters, sets busy=1, -> L1.
//   L1: each cycle hid[k] = sat(ReLU(bias1[k] + sum_i x[i]?w[k][i]:0)); k=0..N_HID-1; -> L2 after k=N_HID-1.
//   L2: each cycle s = sat_ACC(bias2[o] + sum_j w[o][j]*hid[j]); o=0..N_OUT-1.
//  Arithmetic: L1 sum is exact signed; ReLU gives 0 if negative, else min(sum, 2^HID_W-1).
//   L2 products are signed W_W x unsigned HID_W. Sum is exact, then saturates to ACC_W signed range.
//  Argmax: o=0 loads best. Later classes replace best only if s > best (strict), so ties go to the lowest index.
//  Completion: on the o=N_OUT-1 edge, class_out/max_score update, done=1 for one cycle, busy=0, FSM->IDLE.
//  Latency: start-accept edge to done-high is exactly N_HID+N_OUT cycles. Default is 14.
//  start while busy: ignored. A start in the done cycle is accepted, giving back-to-back runs with no bubble.
//  Reset mid-operation: aborts immediately to reset values. The weight file is cleared and no done pulse is produced.
//  Changing x while busy has no effect (latched copy used).
// CONFIGURATION
//  `MLP_SCORE_OUT_EN defined: max_score port exists and is registered with class_out on completion.
//  Not defined: max_score port absent. The best-score register is internal only; class/latency behaviour is identical.
// TESTING
//  T1 reset, all weights 0, start x=8'h00 -> busy 14 cycles, done pulse, class_out=0.
//  T2 w[0][0]=5, L2 w[3][0]=2, rest 0; x=8'h01 -> hid0=5, score3=10, class_out=3, max_score=10.
//  T3 as T2 plus L2 w[7][0]=2 -> tie 10/10, class_out=3 (lowest index wins).
//  T4 bias1[all]=-20, bias2[9]=1, others 0; x=8'hFF with w=0 -> ReLU zeros, class_out=9, max_score=1.
//  T5 w[0][0..7]=511; x=8'hFF; L2 w[0][0]=1 -> hid0 saturates 255, max_score=255, class_out=0.
//  T6 write bias2[5]=100 and pulse start while busy; reset mid-L2 -> write and start dropped; after reset busy=0, done=0, class_out=0.

Source files
------------

// File: rtl/mlp_seq_classifier_if.sv
// Bus interface for mlp_seq_classifier.
// Groups the inference handshake (start/x/busy/done/class_out), the weight
// write port (wr_en/wr_addr/wr_data) and the optional max_score result.
// max_score exists only when MLP_SCORE_OUT_EN is defined.
//   master : drives start, x, wr_en, wr_addr, wr_data; observes the results
//   slave  : the classifier side
interface mlp_seq_classifier_if #(
  parameter int N_IN  = 8,
  parameter int N_HID = 4,
  parameter int N_OUT = 10,
  parameter int W_W   = 10,
  parameter int ACC_W = 20
);
  localparam int DEPTH = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(N_OUT);

  logic                    start;
  logic [N_IN-1:0]         x;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic signed [W_W-1:0]   wr_data;
  logic                    busy;
  logic                    done;
  logic [CW-1:0]           class_out;
`ifdef MLP_SCORE_OUT_EN
  logic signed [ACC_W-1:0] max_score;

  modport master (output start, x, wr_en, wr_addr, wr_data,
                  input  busy, done, class_out, max_score);
  modport slave  (input  start, x, wr_en, wr_addr, wr_data,
                  output busy, done, class_out, max_score);
`else
  modport master (output start, x, wr_en, wr_addr, wr_data,
                  input  busy, done, class_out);
  modport slave  (input  start, x, wr_en, wr_addr, wr_data,
                  output busy, done, class_out);
`endif
endinterface

// File: rtl/mlp_seq_classifier.sv
// Time-multiplexed 2-layer binary-input MLP classifier.
// Layer 1 evaluates one ReLU hidden neuron per cycle, layer 2 one class score
// per cycle while tracking a running argmax (ties keep the lowest index).
// Weights and biases sit in a runtime-writable register file.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (clears FSM, outputs, weights)
//   bus    : mlp_seq_classifier_if.slave (start/x in, wr_* weight writes,
//            busy/done/class_out out, max_score out with MLP_SCORE_OUT_EN)
// Option macro: MLP_SCORE_OUT_EN exposes the registered winning score.
module mlp_seq_classifier #(
  parameter int N_IN  = 8,
  parameter int N_HID = 4,
  parameter int N_OUT = 10,
  parameter int W_W   = 10,
  parameter int HID_W = 8,
  parameter int ACC_W = 20
) (
  input logic                 clk,
  input logic                 rst_n,
  mlp_seq_classifier_if.slave bus
);
  localparam int DEPTH = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1);
  localparam int B2    = N_HID * (N_IN + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(N_OUT);
  localparam int MAXN  = (N_HID > N_OUT) ? N_HID : N_OUT;
  localparam int KW    = $clog2(MAXN);
  localparam int HW    = $clog2(N_HID);
  // Exact-sum widths: one extra bit per doubling of terms plus sign headroom
  localparam int S1_W  = W_W + $clog2(N_IN + 1) + 1;
  localparam int P_W   = W_W + HID_W + 1;
  localparam int S2_W  = P_W + $clog2(N_HID + 1) + 1;

  localparam logic signed [S1_W-1:0] HID_MAX = {{(S1_W-HID_W){1'b0}}, {HID_W{1'b1}}};
  localparam logic signed [S2_W-1:0] SAT_HI  = {{(S2_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [S2_W-1:0] SAT_LO  = {{(S2_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_L1 = 2'd1, ST_L2 = 2'd2} state_t;

  state_t                  state_r, state_nxt_s;
  logic signed [W_W-1:0]   wmem_r [DEPTH];
  logic [HID_W-1:0]        hid_r  [N_HID];
  logic [N_IN-1:0]         x_r;
  logic [KW-1:0]           cnt_r;
  logic                    busy_r, done_r;
  logic [CW-1:0]           class_r, best_idx_r;
  logic signed [ACC_W-1:0] best_r;
  logic [HW-1:0]           hsel_s;
  logic signed [S1_W-1:0]  sum1_s;
  logic [HID_W-1:0]        relu_s;
  logic signed [S2_W-1:0]  sum2_s;
  logic signed [ACC_W-1:0] score_s;
  logic                    take_s, last_hid_s, last_out_s, wr_ok_s;

  assign hsel_s     = cnt_r[HW-1:0];
  assign last_hid_s = (cnt_r == KW'(N_HID - 1));
  assign last_out_s = (cnt_r == KW'(N_OUT - 1));
  assign wr_ok_s    = bus.wr_en && !busy_r && (bus.wr_addr < AW'(DEPTH));

  // Layer-1 neuron: bias plus weights of set input bits, then ReLU with saturation
  always_comb begin
    logic [AW-1:0] a;
    a      = AW'(int'(hsel_s) * (N_IN + 1) + N_IN);
    sum1_s = S1_W'(wmem_r[a]);
    for (int i = 0; i < N_IN; i++) begin
      a = AW'(int'(hsel_s) * (N_IN + 1) + i);
      if (x_r[i]) begin
        sum1_s = sum1_s + S1_W'(wmem_r[a]);
      end else begin
        sum1_s = sum1_s;
      end
    end
    if (sum1_s[S1_W-1]) begin
      relu_s = {HID_W{1'b0}};
    end else if (sum1_s > HID_MAX) begin
      relu_s = {HID_W{1'b1}};
    end else begin
      relu_s = sum1_s[HID_W-1:0];
    end
  end

  // Layer-2 class score: signed weight x unsigned activation, saturated to ACC_W
  always_comb begin
    logic [AW-1:0]         a;
    logic signed [P_W-1:0] wx, hx;
    a      = AW'(B2 + int'(cnt_r) * (N_HID + 1) + N_HID);
    sum2_s = S2_W'(wmem_r[a]);
    for (int j = 0; j < N_HID; j++) begin
      a      = AW'(B2 + int'(cnt_r) * (N_HID + 1) + j);
      wx     = P_W'(wmem_r[a]);
      hx     = P_W'({1'b0, hid_r[j]});
      sum2_s = sum2_s + S2_W'(wx * hx);
    end
    if (sum2_s > SAT_HI) begin
      score_s = SAT_HI[ACC_W-1:0];
    end else if (sum2_s < SAT_LO) begin
      score_s = SAT_LO[ACC_W-1:0];
    end else begin
      score_s = sum2_s[ACC_W-1:0];
    end
  end

  // Argmax update: class 0 always loads, later classes only on a strictly larger score
  always_comb begin
    if (cnt_r == {KW{1'b0}}) begin
      take_s = 1'b1;
    end else begin
      take_s = (score_s > best_r);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_nxt_s = ST_L1;
        else           state_nxt_s = ST_IDLE;
      end
      ST_L1: begin
        if (last_hid_s) state_nxt_s = ST_L2;
        else            state_nxt_s = ST_L1;
      end
      ST_L2: begin
        if (last_out_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_L2;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Weight register file: writes only while idle and in range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < DEPTH; d++) wmem_r[d] <= {W_W{1'b0}};
    end else if (wr_ok_s) begin
      wmem_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Datapath sequencing: input latch, neuron counter, hidden regs, argmax and results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r        <= {N_IN{1'b0}};
      cnt_r      <= {KW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      class_r    <= {CW{1'b0}};
      best_idx_r <= {CW{1'b0}};
      best_r     <= {ACC_W{1'b0}};
      for (int h = 0; h < N_HID; h++) hid_r[h] <= {HID_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            x_r    <= bus.x;
            cnt_r  <= {KW{1'b0}};
            busy_r <= 1'b1;
          end
        end
        ST_L1: begin
          hid_r[hsel_s] <= relu_s;
          if (last_hid_s) cnt_r <= {KW{1'b0}};
          else            cnt_r <= cnt_r + KW'(1);
        end
        ST_L2: begin
          if (take_s) begin
            best_r     <= score_s;
            best_idx_r <= cnt_r[CW-1:0];
          end
          if (last_out_s) begin
            cnt_r   <= {KW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            class_r <= take_s ? cnt_r[CW-1:0] : best_idx_r;
          end else begin
            cnt_r <= cnt_r + KW'(1);
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef MLP_SCORE_OUT_EN
  logic signed [ACC_W-1:0] score_out_r;

  // Winning score, registered together with class_out on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_out_r <= {ACC_W{1'b0}};
    end else if ((state_r == ST_L2) && last_out_s) begin
      score_out_r <= take_s ? score_s : best_r;
    end
  end

  assign bus.max_score = score_out_r;
`endif

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.class_out = class_r;
endmodule

// File: tb/tb_mlp_seq_classifier.sv
// Scoreboard bench for mlp_seq_classifier: a reference model predicts the
// class (and score) when each start is driven; predictions are popped and
// compared when done pulses.
`timescale 1ns/1ps
module tb_mlp_seq_classifier;
  localparam int N_IN = 8, N_HID = 4, N_OUT = 10, W_W = 10, HID_W = 8, ACC_W = 20;
  localparam int DEPTH = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1);
  localparam int B2    = N_HID * (N_IN + 1);
  localparam int LAT   = N_HID + N_OUT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mlp_seq_classifier_if #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT),
                          .W_W(W_W), .ACC_W(ACC_W)) bus ();

  mlp_seq_classifier #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT),
                       .W_W(W_W), .HID_W(HID_W), .ACC_W(ACC_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {int cls; int score;} exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   w_m [DEPTH];
  exp_t sb_q [$];

  task automatic check_val(input string tag, input longint obs, input longint expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t predict(input logic [7:0] xv);
    int   hid [N_HID];
    int   s, best, bi;
    exp_t e;
    best = 0;
    bi   = 0;
    for (int h = 0; h < N_HID; h++) begin
      s = w_m[h * (N_IN + 1) + N_IN];
      for (int i = 0; i < N_IN; i++) if (xv[i]) s += w_m[h * (N_IN + 1) + i];
      hid[h] = (s < 0) ? 0 : ((s > 255) ? 255 : s);
    end
    for (int o = 0; o < N_OUT; o++) begin
      s = w_m[B2 + o * (N_HID + 1) + N_HID];
      for (int j = 0; j < N_HID; j++) s += w_m[B2 + o * (N_HID + 1) + j] * hid[j];
      if (s > 524287) s = 524287;
      if (s < -524288) s = -524288;
      if (o == 0 || s > best) begin
        best = s;
        bi   = o;
      end
    end
    e.cls   = bi;
    e.score = best;
    return e;
  endfunction

  // Idle-time weight write; model follows only in-range addresses
  task automatic wr(input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 7'(addr);
    bus.wr_data = 10'(data);
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (addr < DEPTH) w_m[addr] = data;
  endtask

  task automatic start_run(input logic [7:0] xv);
    bus.start = 1'b1;
    bus.x     = xv;
    sb_q.push_back(predict(xv));
    @(negedge clk);
    bus.start = 1'b0;
    bus.x     = ~xv;
  endtask

  task automatic wait_done(input int lat0, input string tag);
    int   lat;
    exp_t e;
    lat = lat0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_latency"}, lat, LAT);
    if (bus.done === 1'b1) begin
      check_val({tag, "_sb_depth"}, sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_val({tag, "_class"}, bus.class_out, e.cls);
`ifdef MLP_SCORE_OUT_EN
        check_val({tag, "_score"}, $signed(bus.max_score), e.score);
`endif
      end
    end else begin
      sb_q.delete();
    end
  endtask

  task automatic post_run(input string tag);
    @(negedge clk);
    check_val({tag, "_done_pulse"}, bus.done, 0);
    check_val({tag, "_busy_clr"}, bus.busy, 0);
  endtask

  task automatic run(input logic [7:0] xv, input string tag);
    start_run(xv);
    wait_done(0, tag);
    post_run(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < DEPTH; d++) w_m[d] = 0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int seen;
    bus.start   = 1'b0;
    bus.x       = 8'h00;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 7'd0;
    bus.wr_data = 10'sd0;
    for (int d = 0; d < DEPTH; d++) w_m[d] = 0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_class", bus.class_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: all-zero weights
    run(8'h00, "t1");

    // T2: hid0=5, score3=10
    wr(0, 5);
    wr(B2 + 3 * (N_HID + 1), 2);
    run(8'h01, "t2");

    // T3: tie between classes 3 and 7
    wr(B2 + 7 * (N_HID + 1), 2);
    run(8'h01, "t3");

    // Back-to-back: start issued in the done cycle
    start_run(8'h01);
    wait_done(0, "b2b_a");
    start_run(8'h00);
    wait_done(0, "b2b_b");
    post_run("b2b");

    // T4: negative hidden sums clamp to zero, bias2[9] wins
    do_reset();
    for (int h = 0; h < N_HID; h++) wr(h * (N_IN + 1) + N_IN, -20);
    wr(B2 + 9 * (N_HID + 1) + N_HID, 1);
    run(8'hFF, "t4");

    // T5: hidden saturation at 255; an out-of-range write is dropped
    do_reset();
    for (int i = 0; i < N_IN; i++) wr(i, 511);
    wr(B2, 1);
    wr(100, 300);
    run(8'hFF, "t5");

    // Random weights and inputs
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++) wr(a, int'($urandom_range(0, 1023)) - 512);
      run(8'($urandom_range(0, 255)), "rnd");
    end

    // T6a: write and start while busy are both dropped
    do_reset();
    start_run(8'h00);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 7'(B2 + 5 * (N_HID + 1) + N_HID);
    bus.wr_data = 10'sd100;
    bus.start   = 1'b1;
    bus.x       = 8'hFF;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    wait_done(1, "t6_busy");
    post_run("t6_busy");

    // T6b: class 5 result, then reset mid-L2 clears outputs and weights
    wr(B2 + 5 * (N_HID + 1) + N_HID, 100);
    run(8'h00, "t6_pre");
    start_run(8'h00);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    for (int d = 0; d < DEPTH; d++) w_m[d] = 0;
    sb_q.delete();
    #1;
    check_val("t6_rst_busy", bus.busy, 0);
    check_val("t6_rst_done", bus.done, 0);
    check_val("t6_rst_class", bus.class_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    check_val("t6_no_done", seen, 0);
    check_val("t6_idle", bus.busy, 0);
    run(8'h00, "t6_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
